// File: rtl/rv32_mem_pkg.sv
// ---------------------------------------------------------------------------
// rv32_mem_pkg
// Shared definitions for the RV32I data memory / load-store unit:
//   - funct3 width/sign codes used by loads and stores
//   - state encoding of the result-dump FSM
//   - idx_w(): index width helper that never returns zero
// ---------------------------------------------------------------------------
package rv32_mem_pkg;

  // RV32I load/store funct3 codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Dump FSM states
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_e;

  // Width of a counter over n items; a single item still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_dump_fsm.sv
// ---------------------------------------------------------------------------
// dm_dump_fsm
// Sequencer for the result-dump port. Walks word indices 0..DUMP_WORDS-1
// under a valid/ready handshake and tells the storage which word to snapshot.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset
//   dump_start  in   begin a dump (ignored while one is in progress)
//   dump_ready  in   consumer accepts the current word
//   dump_valid  out  current word is valid
//   dump_done   out  one-cycle pulse after the last word is accepted
//   dump_index  out  index of the word currently presented
//   rd_idx      out  word index the storage should read for the snapshot
//   latch_en    out  capture storage word rd_idx into the dump data register
// ---------------------------------------------------------------------------
module dm_dump_fsm
  import rv32_mem_pkg::*;
#(
  parameter int DUMP_WORDS = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dump_start,
  input  logic                          dump_ready,
  output logic                          dump_valid,
  output logic                          dump_done,
  output logic [idx_w(DUMP_WORDS)-1:0]  dump_index,
  output logic [idx_w(DUMP_WORDS)-1:0]  rd_idx,
  output logic                          latch_en
);

  localparam int             IW   = idx_w(DUMP_WORDS);
  localparam logic [IW-1:0]  LAST = IW'(DUMP_WORDS - 1);

  dump_state_e   r_state;
  dump_state_e   w_state_next;
  logic [IW-1:0] r_index;
  logic [IW-1:0] w_index_next;
  logic          r_done;
  logic          w_done_next;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_index <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_index <= w_index_next;
      r_done  <= w_done_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_index_next = r_index;
    w_done_next  = 1'b0;
    latch_en     = 1'b0;
    rd_idx       = r_index;

    unique case (r_state)
      IDLE: begin
        if (dump_start) begin
          w_state_next = SEND;
          w_index_next = '0;
          rd_idx       = '0;
          latch_en     = 1'b1;
        end
      end
      SEND: begin
        // dump_start is deliberately not looked at here.
        if (dump_ready) begin
          if (r_index < LAST) begin
            w_index_next = r_index + IW'(1);
            rd_idx       = r_index + IW'(1);
            latch_en     = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign dump_valid = (r_state == SEND);
  assign dump_done  = r_done;
  assign dump_index = r_index;

endmodule

// File: rtl/data_memory_lsu.sv
// ---------------------------------------------------------------------------
// data_memory_lsu
// Byte-addressed little-endian RV32I data memory with load extension, store
// byte-lane steering, fault detection and a handshaked word-dump port.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-low reset (clears memory and dump)
//   mem_read    in   load request this cycle
//   mem_write   in   store request this cycle
//   funct3      in   RV32I width/sign code
//   addr        in   byte effective address
//   wdata       in   store data (low bits for SB/SH)
//   rdata       out  load result, combinational; 0 when no legal load
//   fault       out  misaligned / out-of-range / illegal funct3 access
//   dump_start  in   begin streaming words 0..DUMP_WORDS-1
//   dump_valid  out  dump_data valid
//   dump_ready  in   consumer accepts the current word
//   dump_index  out  word index of dump_data
//   dump_data   out  registered snapshot of the indexed word
//   dump_done   out  one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module data_memory_lsu
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int DUMP_WORDS  = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mem_read,
  input  logic                          mem_write,
  input  logic [2:0]                    funct3,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata,
  output logic                          fault,
  input  logic                          dump_start,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [idx_w(DUMP_WORDS)-1:0]  dump_index,
  output logic [31:0]                   dump_data,
  output logic                          dump_done
);

  localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int WI_W        = idx_w(DEPTH_WORDS);
  localparam int IW          = idx_w(DUMP_WORDS);

  // -------------------------------------------------------------------------
  // Storage: byte array, viewed as little-endian words for reading
  // -------------------------------------------------------------------------
  logic [7:0]  r_mem   [DEPTH_BYTES];
  logic [31:0] w_words [DEPTH_WORDS];

  for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word_view
    assign w_words[g] = {r_mem[4*g+3], r_mem[4*g+2], r_mem[4*g+1], r_mem[4*g]};
  end

  // -------------------------------------------------------------------------
  // Access decode and fault detection
  // -------------------------------------------------------------------------
  logic [2:0]      w_size;
  logic            w_load_legal;
  logic            w_store_legal;
  logic            w_misalign;
  logic            w_oob;
  logic            w_illegal;
  logic            w_word_ok;
  logic [WI_W-1:0] w_cpu_widx;
  logic [31:0]     w_cpu_word;

  always_comb begin
    w_size = 3'd4;
    unique case (funct3[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
  end

  assign w_load_legal  = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign w_store_legal = funct3 inside {F3_B, F3_H, F3_W};

  assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign w_oob = ({1'b0, addr} + 33'(w_size)) > 33'(DEPTH_BYTES);

  assign w_illegal = (mem_read && !w_load_legal) || (mem_write && !w_store_legal);

  assign fault = (mem_read || mem_write) && (w_illegal || w_misalign || w_oob);

  // Index is forced to 0 when out of range so the array is never read past
  // its end; the result is discarded in that case because fault is set.
  assign w_word_ok  = (addr[31:2] < 30'(DEPTH_WORDS));
  assign w_cpu_widx = w_word_ok ? addr[WI_W+1:2] : '0;
  assign w_cpu_word = w_words[w_cpu_widx];

  // -------------------------------------------------------------------------
  // Load path: lane select and extension
  // -------------------------------------------------------------------------
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  always_comb begin
    w_ld_byte = w_cpu_word[7:0];
    unique case (addr[1:0])
      2'd0: w_ld_byte = w_cpu_word[7:0];
      2'd1: w_ld_byte = w_cpu_word[15:8];
      2'd2: w_ld_byte = w_cpu_word[23:16];
      2'd3: w_ld_byte = w_cpu_word[31:24];
    endcase
  end

  assign w_ld_half = addr[1] ? w_cpu_word[31:16] : w_cpu_word[15:0];

  always_comb begin
    rdata = '0;
    if (mem_read && !fault) begin
      unique case (funct3)
        F3_B:    rdata = {{24{w_ld_byte[7]}}, w_ld_byte};
        F3_BU:   rdata = {24'd0, w_ld_byte};
        F3_H:    rdata = {{16{w_ld_half[15]}}, w_ld_half};
        F3_HU:   rdata = {16'd0, w_ld_half};
        F3_W:    rdata = w_cpu_word;
        default: rdata = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Store path: byte enables and lane-replicated data
  // -------------------------------------------------------------------------
  logic [3:0]  w_be;
  logic [31:0] w_wlanes;
  logic        w_store_en;

  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        w_be     = 4'b0001 << addr[1:0];
        w_wlanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be     = addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wlanes = wdata;
      end
    endcase
  end

  assign w_store_en = mem_write && !fault;

  // NOTE: the storage is built from flops and is cleared by reset because the
  // contents must read as zero after reset; a RAM macro could not do this.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem <= '{default: '0};
    end else if (w_store_en) begin
      if (w_be[0]) r_mem[{w_cpu_widx, 2'd0}] <= w_wlanes[7:0];
      if (w_be[1]) r_mem[{w_cpu_widx, 2'd1}] <= w_wlanes[15:8];
      if (w_be[2]) r_mem[{w_cpu_widx, 2'd2}] <= w_wlanes[23:16];
      if (w_be[3]) r_mem[{w_cpu_widx, 2'd3}] <= w_wlanes[31:24];
    end
  end

  // -------------------------------------------------------------------------
  // Dump port
  // -------------------------------------------------------------------------
  logic [IW-1:0] w_rd_idx;
  logic          w_latch_en;
  logic [31:0]   r_dump_data;

  dm_dump_fsm #(
    .DUMP_WORDS (DUMP_WORDS)
  ) u_dump_fsm (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .dump_index (dump_index),
    .rd_idx     (w_rd_idx),
    .latch_en   (w_latch_en)
  );

  // Snapshot reads r_mem before this edge's store lands, so a store to the
  // word being latched shows up only in later reads, not in dump_data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dump_data <= '0;
    end else if (w_latch_en) begin
      r_dump_data <= w_words[WI_W'(w_rd_idx)];
    end
  end

  assign dump_data = r_dump_data;

endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;
  import rv32_mem_pkg::*;

  localparam int DEPTH_BYTES = 256;
  localparam int DUMP_WORDS  = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        fault;
  logic        dump_start, dump_valid, dump_ready, dump_done;
  logic [2:0]  dump_index;
  logic [31:0] dump_data;

  always #5 clk = ~clk;

  data_memory_lsu #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .DUMP_WORDS  (DUMP_WORDS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .fault      (fault),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_index (dump_index),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic ef);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.d = d;
    v.exp_rdata = er; v.exp_fault = ef;
    return v;
  endfunction

  task automatic bus_idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;
  endtask

  // Called just after a negedge; leaves off just after the next negedge.
  task automatic store_word(input logic [31:0] a, input logic [31:0] d);
    mem_read = 1'b0; mem_write = 1'b1; funct3 = F3_W; addr = a; wdata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic load_check(input string name, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] exp);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a; wdata = '0;
    #1;
    check(name, rdata, exp);
    bus_idle();
  endtask

  initial begin
    int  cyc;
    int  got;
    logic rdy;

    reset = 1'b0;
    bus_idle();
    dump_start = 1'b0;
    dump_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset dump_valid", 32'(dump_valid), 32'd0);
    check("reset dump_done",  32'(dump_done),  32'd0);
    check("reset dump_index", 32'(dump_index), 32'd0);
    check("reset dump_data",  dump_data,       32'd0);
    load_check("reset LW 0", F3_W, 32'd0, 32'd0);
    @(negedge clk);

    // ---- table-driven load/store/fault vectors (one per cycle) ----
    //                   rd    wr    f3      addr           wdata          rdata         fault
    vecs.push_back(mk(1'b0, 1'b1, F3_W,  32'd8,         32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'd8,         32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_BU, 32'd8,         32'h0,        32'h000000EF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_B,  32'd11,        32'h0,        32'hFFFFFFDE, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_HU, 32'd10,        32'h0,        32'h0000DEAD, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_H,  32'd10,        32'h0,        32'hFFFFDEAD, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_B,  32'd8,         32'h0,        32'hFFFFFFEF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_H,  32'd8,         32'h0,        32'hFFFFBEEF, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, F3_B,  32'd1,         32'hFFFFFF80, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 1'b1, F3_H,  32'd2,         32'hABCD1234, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'd0,         32'h0,        32'h12348000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_H,  32'd0,         32'h0,        32'hFFFF8000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_HU, 32'd2,         32'h0,        32'h00001234, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_BU, 32'd1,         32'h0,        32'h00000080, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, F3_W,  32'd4,         32'h11223344, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 1'b1, F3_W,  32'd6,         32'h55555555, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'd4,         32'h0,        32'h11223344, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_H,  32'd3,         32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 1'b1, F3_W,  32'd256,       32'h77777777, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'd252,       32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 1'b1, F3_W,  32'd252,       32'hCAFEF00D, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'd252,       32'h0,        32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_B,  32'd255,       32'h0,        32'hFFFFFFCA, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_BU, 32'd256,       32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'd253,       32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 1'b0, F3_H,  32'd254,       32'h0,        32'hFFFFCAFE, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'b011, 32'd0,        32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 3'b100, 32'd0,        32'hFFFFFFFF, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'd0,         32'h0,        32'h12348000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 3'b011, 32'd3,        32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b1, F3_W,  32'd0,         32'h0BADCAFE, 32'h12348000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'd0,         32'h0,        32'h0BADCAFE, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_H,  32'hFFFFFFFE,  32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 1'b1, F3_B,  32'd255,       32'h0000005A, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_BU, 32'd255,       32'h0,        32'h0000005A, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'd252,       32'h0,        32'h5AFEF00D, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, F3_H,  32'd5,         32'h99999999, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 1'b0, F3_W,  32'd4,         32'h0,        32'h11223344, 1'b0));

    foreach (vecs[i]) begin
      mem_read  = vecs[i].rd;
      mem_write = vecs[i].wr;
      funct3    = vecs[i].f3;
      addr      = vecs[i].a;
      wdata     = vecs[i].d;
      #1;
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d fault", i), 32'(fault), 32'(vecs[i].exp_fault));
      @(negedge clk);
    end
    bus_idle();

    // ---- dump with alternating backpressure ----
    for (int i = 0; i < DUMP_WORDS; i++) store_word(32'(4 * i), 32'h100 + 32'(i));
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    got = 0;
    cyc = 0;
    while (got < DUMP_WORDS && cyc < 40) begin
      #1;
      check($sformatf("bp valid c%0d", cyc), 32'(dump_valid), 32'd1);
      check($sformatf("bp index c%0d", cyc), 32'(dump_index), 32'(got));
      check($sformatf("bp data c%0d", cyc),  dump_data, 32'h100 + 32'(got));
      check($sformatf("bp done c%0d", cyc),  32'(dump_done), 32'd0);
      rdy        = (cyc % 2 == 0);
      dump_ready = rdy;
      dump_start = (cyc == 3);
      @(negedge clk);
      if (rdy) got++;
      cyc++;
    end
    check("bp words accepted", 32'(got), 32'(DUMP_WORDS));
    dump_start = 1'b0;
    dump_ready = 1'b0;
    #1;
    check("bp end valid", 32'(dump_valid), 32'd0);
    check("bp end done",  32'(dump_done),  32'd1);
    @(negedge clk);
    #1;
    check("bp done pulse width", 32'(dump_done),  32'd0);
    check("bp no restart",       32'(dump_valid), 32'd0);

    // ---- snapshot collision: store to word 1 as it is latched ----
    @(negedge clk);
    dump_ready = 1'b1;
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    mem_write = 1'b1; funct3 = F3_W; addr = 32'd4; wdata = 32'h0000AAAA;
    #1;
    check("snap idx0", 32'(dump_index), 32'd0);
    check("snap data0", dump_data, 32'h100);
    @(negedge clk);
    bus_idle();
    #1;
    check("snap idx1", 32'(dump_index), 32'd1);
    check("snap data1 old", dump_data, 32'h101);
    for (int i = 2; i < DUMP_WORDS; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("snap data%0d", i), dump_data, 32'h100 + 32'(i));
    end
    @(negedge clk);
    #1;
    check("snap done", 32'(dump_done), 32'd1);
    load_check("snap LW 4", F3_W, 32'd4, 32'h0000AAAA);
    @(negedge clk);

    // ---- reset in the middle of a dump ----
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    cyc = 0;
    while (dump_index != 3'd3 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("mid index before reset", 32'(dump_index), 32'd3);
    reset = 1'b0;
    mem_write = 1'b1; funct3 = F3_W; addr = 32'd16; wdata = 32'h77777777;
    @(negedge clk);
    reset = 1'b1;
    bus_idle();
    dump_ready = 1'b0;
    #1;
    check("mid valid", 32'(dump_valid), 32'd0);
    check("mid done",  32'(dump_done),  32'd0);
    check("mid index", 32'(dump_index), 32'd0);
    check("mid data",  dump_data,       32'd0);
    load_check("mid LW 0",   F3_W, 32'd0,   32'd0);
    load_check("mid LW 16",  F3_W, 32'd16,  32'd0);
    load_check("mid LW 252", F3_W, 32'd252, 32'd0);
    @(negedge clk);
    dump_ready = 1'b1;
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    for (int i = 0; i < DUMP_WORDS; i++) begin
      #1;
      check($sformatf("zero valid%0d", i), 32'(dump_valid), 32'd1);
      check($sformatf("zero index%0d", i), 32'(dump_index), 32'(i));
      check($sformatf("zero data%0d", i),  dump_data,       32'd0);
      @(negedge clk);
    end
    #1;
    check("zero done", 32'(dump_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
# data_memory_lsu

Byte-addressed RV32I data memory with integrated load/store alignment logic and a handshaked result-dump port. Sits directly downstream of the Processor datapath's ALU/address stage: it consumes effective address, store data and funct3, and returns load data to write-back. The dump port streams the first DUMP_WORDS memory words out as little-endian 32-bit values for bench checking. This replaces hierarchical peeking into memory.

## Interface
- DEPTH_BYTES, 256: memory size in bytes; must be a multiple of 4.
- DUMP_WORDS, 7: number of words streamed per dump, starting at word 0; must be ≤ DEPTH_BYTES/4.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; one clock; sampled only on clk rising edge.
- mem_read  in  1  load request this cycle.
- mem_write  in  1  store request this cycle.
- funct3  in  3  RV32I load/store width and sign code.
- addr  in  32  byte effective address.
- wdata  in  32  store data; low bits are used for SB/SH.
- rdata  out  32  load result, extended per funct3; combinational.
- fault  out  1  access is misaligned or out of range; combinational.
- dump_start  in  1  single-cycle request to begin a dump.
- dump_valid  out  1  dump_data is valid.
- dump_ready  in  1  consumer accepts the current word.
- dump_index  out  $clog2(DUMP_WORDS)  word index of dump_data.
- dump_data  out  32  word value, {Mem[4i+3],Mem[4i+2],Mem[4i+1],Mem[4i]}.
- dump_done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- Storage is an array of DEPTH_BYTES bytes. It is little-endian: byte addr holds the LSB.
- Loads (mem_read=1):
  - LB=000 and LBU=100 select byte addr.
  - LH=001 and LHU=101 select bytes addr and addr+1.
  - LW=010 selects 4 bytes.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Other funct3 values set fault=1.
- Stores (mem_write=1): SB=000, SH=001, SW=010 write 1, 2 or 4 bytes. Other funct3 values set fault=1.
- Fault conditions:
  - Half-word access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Any access with addr+size > DEPTH_BYTES.
  - Illegal funct3.
- Fault response: store suppressed (no byte written), rdata=0.
- When mem_read=0, rdata=0. fault is only asserted when mem_read or mem_write is 1.
- mem_read and mem_write both 1: the store takes effect at the edge. rdata shows pre-store contents in that cycle.
- Dump FSM states: IDLE, SEND.
  - IDLE to SEND on dump_start=1. Sets index←0 and latches word 0 into dump_data.
  - In SEND, when dump_valid and dump_ready are both high:
    - If index<DUMP_WORDS-1: index increments and the next word is latched.
    - Otherwise: go to IDLE and pulse dump_done.
  - dump_start in SEND is ignored.
- dump_data is a registered snapshot taken when the word is latched. A store to that word in the latching cycle is not reflected; the old value is captured.
- Reset (reset=0 at an edge), including mid-dump:
  - All memory bytes become 0.
  - FSM goes to IDLE.
  - dump_valid=0, dump_done=0, dump_index=0, dump_data=0.
  - A store in the reset cycle is discarded.

## Timing
- Store: committed at the rising edge where mem_write=1 and fault=0. Visible to a load in the next cycle.
- Load: zero latency. rdata and fault are valid in the same cycle as addr/funct3.
- Dump:
  - dump_start sampled at edge k gives dump_valid=1 with word 0 from after edge k.
  - With dump_ready held at 1, one word is accepted per cycle with no bubbles. DUMP_WORDS words take DUMP_WORDS cycles.
  - dump_valid, dump_index and dump_data are stable while dump_ready=0.
  - After the final handshake edge: dump_valid=0 and dump_done=1 for exactly one cycle.
  - A new dump_start is accepted in the dump_done cycle.

## Structure
- Shared package rv32_mem_pkg holds:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - Dump FSM state enum {IDLE, SEND}.
- One sub-module, dm_dump_fsm. It owns the FSM, index counter and dump_valid/dump_done. It drives a word-read index into the storage and a latch enable.
- Alignment, extension and byte-lane write logic stay in the top module.

## Test plan
- Word round trip: SW 0xDEADBEEF to addr 8, then LW 8 → rdata=0xDEADBEEF. LBU 8 → 0xEF. LB 11 → 0xFFFFFFDE. LHU 10 → 0x0000DEAD.
- Byte lanes: reset, then SB 0x80 to addr 1 and SH 0x1234 to addr 2. LW 0 → 0x12348000. LH 0 → 0xFFFF8000.
- Faults:
  - SW to addr 6 → fault=1, word 4 unchanged.
  - LH addr 3 → fault=1, rdata=0.
  - SW to addr 256 (DEPTH_BYTES=256) → fault=1.
  - funct3=011 load → fault=1.
- Dump with backpressure:
  - Setup: write word i = 0x100+i for i=0..6, then pulse dump_start.
  - Stimulus: toggle dump_ready 1,0,1,…
  - Required: seven words 0x100..0x106 in index order; data held stable while ready=0; dump_done pulses once; dump_start during SEND ignored.
- Snapshot collision: SW 0xAAAA to addr 4 in the same cycle word 1 is latched → dump shows the old value. A subsequent LW 4 → 0xAAAA.
- Reset mid-dump: reset=0 for one edge at index 3 → dump_valid=0 the next cycle, all outputs 0, LW 0 → 0. A new dump then returns seven zero words.
